// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: in-place NTT butterfly sequencer for one PE; NTT_SCHED_HOLD_EN adds an issue-stall input hold
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
module ntt_stage_sched #(
  parameter int LOGN   = 8,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef NTT_SCHED_HOLD_EN
  input  logic                      hold,
`endif
  input  logic [`DATA_SIZE_ARB-1:0] q_cfg,
  output logic [`DATA_SIZE_ARB-1:0] q,
  output logic                      rd_en,
  output logic [LOGN-1:0]           rd_top_addr,
  output logic [LOGN-1:0]           rd_bot_addr,
  output logic [LOGN-1:0]           tw_addr,
  output logic                      wr_en,
  output logic [LOGN-1:0]           wr_top_addr,
  output logic [LOGN-1:0]           wr_bot_addr,
  output logic [LOGN-1:0]           stage,
  output logic                      busy,
  output logic                      done
);
  localparam int N = 1 << LOGN;
  localparam int TOT_LAT = RD_LAT + PE_LAT;
  localparam logic [LOGN-1:0] ONE = LOGN'(1);
  localparam logic [LOGN-1:0] HALF0 = LOGN'(N / 2);
  localparam logic [LOGN-1:0] LAST_B = LOGN'(N / 2 - 1);
  localparam logic [LOGN-1:0] LAST_S = LOGN'(LOGN - 1);
  localparam logic [7:0] LAST_D = 8'(TOT_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t st, st_n;
  logic [LOGN-1:0] s, b, half, j, g, top;
  logic [7:0] dcnt;
  logic stall;
  logic vp [TOT_LAT];
  logic [LOGN-1:0] tp [TOT_LAT];
  logic [LOGN-1:0] bp [TOT_LAT];

`ifdef NTT_SCHED_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign stage = s;
  assign busy = st != S_IDLE;
  assign wr_en = vp[TOT_LAT-1];
  assign wr_top_addr = tp[TOT_LAT-1];
  assign wr_bot_addr = bp[TOT_LAT-1];

  // butterfly addressing: group g, offset j within group, span half
  always_comb begin
    half = HALF0 >> s;
    j = b & (half - ONE);
    g = b >> (LAST_S - s);
    top = (g << (LOGN - int'(s))) | j;
    rd_top_addr = (st == S_ISSUE) ? top : '0;
    rd_bot_addr = (st == S_ISSUE) ? top + half : '0;
    tw_addr = (st == S_ISSUE) ? (ONE << s) + g : '0;
  end

  // next state, read strobe and done pulse
  always_comb begin
    st_n = st;
    rd_en = 1'b0;
    done = 1'b0;
    case (st)
      S_IDLE:  st_n = start ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        rd_en = !stall;
        st_n = (!stall && b == LAST_B) ? S_DRAIN : S_ISSUE;
      end
      S_DRAIN: st_n = (dcnt == LAST_D) ? ((s == LAST_S) ? S_DONE : S_ISSUE) : S_DRAIN;
      default: begin
        done = 1'b1;
        st_n = S_IDLE;
      end
    endcase
  end

  // state, counters and latched modulus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= S_IDLE;
      s <= '0;
      b <= '0;
      dcnt <= '0;
      q <= '0;
    end else begin
      st <= st_n;
      if (st == S_IDLE && start) begin
        q <= q_cfg;
        s <= '0;
        b <= '0;
      end
      if (rd_en) b <= (b == LAST_B) ? '0 : b + ONE;
      dcnt <= (st == S_DRAIN) ? dcnt + 8'd1 : '0;
      if (st == S_DRAIN && st_n == S_ISSUE) s <= s + ONE;
    end
  end

  // read-to-write delay line matching memory plus PE latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TOT_LAT; i++) begin
        vp[i] <= 1'b0;
        tp[i] <= '0;
        bp[i] <= '0;
      end
    end else begin
      vp[0] <= rd_en;
      tp[0] <= rd_top_addr;
      bp[0] <= rd_bot_addr;
      for (int i = 1; i < TOT_LAT; i++) begin
        vp[i] <= vp[i-1];
        tp[i] <= tp[i-1];
        bp[i] <= bp[i-1];
      end
    end
  end
endmodule
